// File: rtl/dm_responder.sv
// dm_responder: data-memory responder with configurable wait states and
// little-endian word/half/byte access on an internal word array.
module dm_responder #(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  MemDst,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we, r_sign;
  logic [1:0]  r_dst;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_mem [DEPTH];
  logic        w_take, w_go, w_we, w_sign, w_err;
  logic [1:0]  w_dst;
  logic [31:0] w_addr, w_wdata, w_word, w_load, w_store;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [ADDR_W-3:0] w_idx;
  // With WAIT=0 the ACK edge is the acceptance edge, so use live inputs there
  assign w_take  = r_state == S_IDLE;
  assign w_go    = w_take ? (req && WAIT == 0) : (r_state == S_WAIT && r_cnt == 4'd1);
  assign w_we    = w_take ? we     : r_we;
  assign w_dst   = w_take ? MemDst : r_dst;
  assign w_sign  = w_take ? sign   : r_sign;
  assign w_addr  = w_take ? addr   : r_addr;
  assign w_wdata = w_take ? wdata  : r_wdata;
  assign w_err   = (w_dst == 2'b11) || (w_dst == 2'b00 && w_addr[1:0] != 2'b00) ||
                   (w_dst == 2'b01 && w_addr[0]) || (|w_addr[31:ADDR_W]);
  assign w_idx   = w_addr[ADDR_W-1:2];
  assign w_word  = r_mem[w_idx];
  assign w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte  = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_load  = w_dst == 2'b00 ? w_word :
                   w_dst == 2'b01 ? {{16{w_sign & w_half[15]}}, w_half} :
                                    {{24{w_sign & w_byte[7]}}, w_byte};
  assign busy    = r_state != S_IDLE;
  always_comb begin
    w_store = w_word;
    if (w_dst == 2'b00) w_store = w_wdata;
    else if (w_dst == 2'b01) w_store[{w_addr[1], 4'b0000} +: 16] = w_wdata[15:0];
    else w_store[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_dst   <= '0;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      ack   <= w_go;
      err   <= w_go && w_err;
      rdata <= (w_go && !w_err && !w_we) ? w_load : '0;
      if (w_go && !w_err && w_we) r_mem[w_idx] <= w_store;
      case (r_state)
        S_IDLE: if (req) begin
          r_we    <= we;
          r_dst   <= MemDst;
          r_sign  <= sign;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_cnt   <= 4'(WAIT);
          r_state <= WAIT == 0 ? S_ACK : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACK;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: table-driven check of dm_responder (WAIT=2) plus reset-abort
// and back-to-back corner cases on a WAIT=0 instance sharing the request bus.
module tb_dm_responder;
  logic        Clk = 1'b0, Reset = 1'b1, req = 1'b0, we = 1'b0, sign = 1'b0;
  logic [1:0]  MemDst = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, rdata0;
  logic        ack, err, busy, ack0, err0, busy0;
  int          n_chk = 0, n_fail = 0;

  dm_responder #(.ADDR_W(12), .WAIT(2)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .MemDst(MemDst), .sign(sign),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy));
  dm_responder #(.ADDR_W(12), .WAIT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .MemDst(MemDst), .sign(sign),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0));

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [1:0]  dst;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  localparam int NV = 23;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xact(input int id, input vec_t t);
    int n, bh;
    @(negedge Clk);
    we = t.we; MemDst = t.dst; sign = t.sign; addr = t.addr; wdata = t.wdata; req = 1'b1;
    n = 0; bh = 0;
    do begin
      @(posedge Clk); #1;
      n++;
      if (busy) bh++;
    end while (!ack && n < 20);
    req = 1'b0;
    chk($sformatf("v%0d latency", id), n, 3);
    chk($sformatf("v%0d busy cycles", id), bh, 3);
    chk($sformatf("v%0d err", id), {31'b0, err}, {31'b0, t.err});
    chk($sformatf("v%0d rdata", id), rdata, t.rdata);
    @(posedge Clk); #1;
    chk($sformatf("v%0d ack drop", id), {31'b0, ack}, 32'd0);
    chk($sformatf("v%0d rdata idle", id), rdata, 32'd0);
    chk($sformatf("v%0d busy idle", id), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] exp6 [4];
    v[0]  = '{1'b1, 2'd0, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 2'd2, 1'b0, 32'h13,   32'h000000A5, 32'h0,        1'b0};
    v[3]  = '{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'hA5ADBEEF, 1'b0};
    v[4]  = '{1'b0, 2'd2, 1'b1, 32'h13,   32'h0,        32'hFFFFFFA5, 1'b0};
    v[5]  = '{1'b0, 2'd2, 1'b0, 32'h13,   32'h0,        32'h000000A5, 1'b0};
    v[6]  = '{1'b1, 2'd1, 1'b0, 32'h12,   32'hFFFF1234, 32'h0,        1'b0};
    v[7]  = '{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'h1234BEEF, 1'b0};
    v[8]  = '{1'b0, 2'd1, 1'b1, 32'h11,   32'h0,        32'h0,        1'b1};
    v[9]  = '{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'h1234BEEF, 1'b0};
    v[10] = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'h00001234, 1'b0};
    v[11] = '{1'b0, 2'd2, 1'b1, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0};
    v[12] = '{1'b0, 2'd1, 1'b0, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
    v[13] = '{1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0};
    v[14] = '{1'b1, 2'd0, 1'b0, 32'h1000, 32'h55,       32'h0,        1'b1};
    v[15] = '{1'b0, 2'd3, 1'b0, 32'h0,    32'h0,        32'h0,        1'b1};
    v[16] = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h0,        32'h0,        1'b0};
    v[17] = '{1'b1, 2'd0, 1'b0, 32'h40,   32'h01234567, 32'h0,        1'b0};
    v[18] = '{1'b1, 2'd0, 1'b0, 32'h44,   32'h89ABCDEF, 32'h0,        1'b0};
    v[19] = '{1'b1, 2'd0, 1'b0, 32'h48,   32'h13579BDF, 32'h0,        1'b0};
    v[20] = '{1'b1, 2'd0, 1'b0, 32'h4C,   32'h2468ACE0, 32'h0,        1'b0};
    v[21] = '{1'b1, 2'd0, 1'b0, 32'h42,   32'hFFFFFFFF, 32'h0,        1'b1};
    v[22] = '{1'b0, 2'd2, 1'b0, 32'h11,   32'h0,        32'h000000BE, 1'b0};
    exp6 = '{32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0};

    repeat (2) @(posedge Clk);
    #1;
    chk("reset ack", {31'b0, ack}, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) xact(i, v[i]);

    // Reset while in WAIT: the store must be dropped and no ack may appear
    @(negedge Clk);
    we = 1'b1; MemDst = 2'd0; sign = 1'b0; addr = 32'h20; wdata = 32'hCAFEF00D; req = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    chk("abort in wait", {31'b0, busy}, 32'd1);
    Reset = 1'b1; req = 1'b0;
    @(posedge Clk); #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort ack", {31'b0, ack}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (ack) seen++;
    end
    chk("abort no ack", seen, 0);
    xact(100, '{1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0});

    // Re-populate after the reset cleared the arrays, then stream loads at WAIT=0
    for (int i = 17; i <= 20; i++) xact(i, v[i]);
    @(negedge Clk);
    we = 1'b0; MemDst = 2'd0; sign = 1'b0; addr = 32'h40; req = 1'b1;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("b2b ack c%0d", k), {31'b0, ack0}, {31'b0, k[0]});
      if (ack0 && seen < 4) begin
        chk($sformatf("b2b rdata %0d", seen), rdata0, exp6[seen]);
        seen++;
        addr = 32'h40 + 32'(seen * 4);
      end
    end
    req = 1'b0;
    chk("b2b count", seen, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the MIPS core's load/store port, sitting on the memory side of the datapath.
- The CPU side issues a request with address, write enable, size (MemDst) and sign flag, then holds it until acknowledged.
- The block adds a configurable number of wait states, performs the little-endian word/half/byte access on an internal word array, and returns read data plus an error flag with a one-cycle ack.
- Used by the upcoming multi-cycle/stalling core and by memory-latency tests.

Parameters:
ADDR_W, 12, byte-address bits backed by storage (2^(ADDR_W-2) words; 4 KiB default)
WAIT, 2, wait states inserted before ack (legal 0..15)

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
req  in  1  request valid; held stable with all request fields until ack
we  in  1  1 = store, 0 = load
MemDst  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved
sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend (lb/lh vs lbu/lhu)
addr  in  32  byte address
wdata  in  32  store data; half/byte taken from low bits
rdata  out  32  load result; valid only in the ack cycle, 0 otherwise
ack  out  1  one-cycle completion pulse
err  out  1  valid with ack: access rejected
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is synchronous and active-high.
  - Effects: state=IDLE; ack=0, err=0, rdata=0, busy=0; the whole word array is cleared to 0.
  - Reset mid-transaction abandons it: no write is committed and no ack is issued.
- FSM has three states: IDLE, WAIT, ACK.
  - IDLE: on an edge with req=1, latch addr/we/MemDst/sign/wdata (the acceptance edge E0). If WAIT=0, go to ACK; else load cnt=WAIT and go to WAIT.
  - WAIT: decrement cnt each edge. On the edge where cnt==1, go to ACK.
  - ACK: ack=1 for exactly one cycle, then unconditionally back to IDLE. req is ignored in ACK.
- Latency:
  - ack is high in the cycle after edge E0+WAIT, i.e. WAIT+1 cycles after the request is first sampled.
  - Minimum spacing between acceptances is WAIT+2 cycles.
- req handshake:
  - Requester must drop req, or present a new request, in the cycle after ack.
  - req high in IDLE is always treated as a new request.
- Outputs (rdata, ack, err) are registered and computed on the edge entering ACK. Store commits to the array on that same edge.
- Error check, evaluated on the latched request:
  - err=1 if any of: MemDst=11; MemDst=00 with addr[1:0]≠0; MemDst=01 with addr[0]=1; addr ≥ 2^ADDR_W.
  - On err: no write, rdata=0, same latency, ack still pulses.
- Word index is addr[ADDR_W-1:2]. Byte lanes are little-endian: byte n = bits [8n+7:8n].
- Stores:
  - Word: replace all 32 bits.
  - Half: replace lane pair addr[1] with wdata[15:0], other half preserved.
  - Byte: replace lane addr[1:0] with wdata[7:0], other lanes preserved.
- Loads:
  - Word: returned unmodified.
  - Half/byte: extract the selected lanes, then sign- or zero-extend per the latched sign.
  - Stores return rdata=0.
- Outside the ACK cycle: ack=0, err=0, rdata=0.
- Changes to the input fields after acceptance have no effect on the in-flight transaction.

Test Plan:
1. Reset, WAIT=2: sw 0xDEADBEEF @0x10, then lw @0x10 → each ack exactly 3 cycles after req first sampled; read gives rdata=0xDEADBEEF, err=0, busy high for 3 cycles per transaction.
2. sb wdata=0x000000A5 @0x13 → lw @0x10 = 0xA5ADBEEF; lb @0x13 = 0xFFFFFFA5; lbu @0x13 = 0x000000A5.
3. sh 0x1234 @0x12 → lw @0x10 = 0x1234BEEF; lh @0x11 → ack with err=1, rdata=0; lw @0x10 still 0x1234BEEF.
4. sw 0x55 @0x1000 (out of range) and MemDst=11 @0x0 → both ack with err=1; lw @0x0 = 0x00000000.
5. sw 0xCAFEF00D @0x20, Reset pulsed one cycle while in WAIT → no ack ever; busy=0 the cycle after reset; subsequent lw @0x20 = 0x00000000.
6. WAIT=0 instance: req held high continuously across four lw requests → ack every 2nd cycle (1 cycle after each acceptance); no duplicate ack from req sampled in the ACK cycle.
